decode_stage: RTL

Instruction-decode stage of the or1420 pipeline, directly downstream of the fetch stage. Consumes the registered fetch word, PC and link address; drives register-file read addresses, resolves control flow (jumps/branches back to fetch via `doJump`/`jumpTarget`) and detects load-use hazards (`insertNop` to fetch). Produces a registered decode→execute pipeline word.

---
 rtl/decode_stage_pkg.sv | 59 +++++
 rtl/decode_stage_immediate.sv | 19 +
 rtl/decode_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/decode_stage_pkg.sv
// Shared opcodes, constants and the decode->execute payload for the or1420 decode stage.
package or1420Pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned PC_W   = 30;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OPC_W  = 6;

  localparam logic [OPC_W-1:0] OPC_J        = 6'h00;
  localparam logic [OPC_W-1:0] OPC_JAL      = 6'h01;
  localparam logic [OPC_W-1:0] OPC_BNF      = 6'h03;
  localparam logic [OPC_W-1:0] OPC_BF       = 6'h04;
  localparam logic [OPC_W-1:0] OPC_NOP      = 6'h05;
  localparam logic [OPC_W-1:0] OPC_JR       = 6'h11;
  localparam logic [OPC_W-1:0] OPC_JALR     = 6'h12;
  localparam logic [OPC_W-1:0] OPC_LOAD_LO  = 6'h21;
  localparam logic [OPC_W-1:0] OPC_LOAD_HI  = 6'h26;
  localparam logic [OPC_W-1:0] OPC_ANDI     = 6'h29;
  localparam logic [OPC_W-1:0] OPC_ORI      = 6'h2A;
  localparam logic [OPC_W-1:0] OPC_SHIFTI   = 6'h2E;
  localparam logic [OPC_W-1:0] OPC_STORE_LO = 6'h35;
  localparam logic [OPC_W-1:0] OPC_STORE_HI = 6'h37;

  localparam logic [WORD_W-1:0] NOP_INSTRUCTION_DEFAULT = 32'h1500FFFF;
  localparam logic [REG_W-1:0]  LINK_REG                = 5'd9;

  typedef enum logic [1:0] {
    IMM_SEXT16,
    IMM_ZEXT16,
    IMM_STORE
  } imm_kind_e;

  // Registered decode->execute pipeline word.
  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] instruction;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   link_address;
    logic [WORD_W-1:0] immediate;
    logic              is_load;
    logic [REG_W-1:0]  write_reg;
  } exe_word_t;

  function automatic imm_kind_e imm_kind(input logic [OPC_W-1:0] opc);
    imm_kind_e kind;
    kind = IMM_SEXT16;
    if (opc == OPC_ANDI || opc == OPC_ORI || opc == OPC_SHIFTI) begin
      kind = IMM_ZEXT16;
    end else if (opc >= OPC_STORE_LO && opc <= OPC_STORE_HI) begin
      kind = IMM_STORE;
    end
    return kind;
  endfunction

  function automatic logic is_load(input logic [OPC_W-1:0] opc);
    return (opc >= OPC_LOAD_LO) && (opc <= OPC_LOAD_HI);
  endfunction

endpackage

// File: rtl/decode_stage_immediate.sv
// Combinational immediate extraction: zero-extend logic/shift immediates, split field for stores.
module immediateGenerator
  import or1420Pkg::*;
(
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic [25:0]       i_fields,
  output logic [WORD_W-1:0] o_immediate_c
);

  always_comb begin
    o_immediate_c = {{16{i_fields[15]}}, i_fields[15:0]};
    case (imm_kind(i_opcode))
      IMM_ZEXT16: o_immediate_c = {16'h0000, i_fields[15:0]};
      IMM_STORE:  o_immediate_c = {{16{i_fields[25]}}, i_fields[25:21], i_fields[10:0]};
      default:    ;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// or1420 decode stage: register read addresses, control-flow resolution,
// load-use hazard detection and the registered decode->execute word.
module decode_stage
  import or1420Pkg::*;
#(
  parameter logic [31:0] NOP_INSTRUCTION = NOP_INSTRUCTION_DEFAULT
) (
  input  logic        cpuClock,
  input  logic        cpuReset,
  input  logic        stallIn,
  input  logic [31:0] instruction,
  input  logic        validInstruction,
  input  logic [31:2] programCounter,
  input  logic [31:2] linkAddress,
  input  logic        flagIn,
  input  logic [31:0] jumpRegisterValue,
  output logic        doJump,
  output logic [31:2] jumpTarget,
  output logic        insertNop,
  output logic [4:0]  regAAddr,
  output logic [4:0]  regBAddr,
  output logic [31:0] exeInstruction,
  output logic [31:2] exePc,
  output logic [31:2] exeLinkAddress,
  output logic [31:0] exeImmediate,
  output logic        exeValid,
  output logic        exeIsLoad,
  output logic [4:0]  exeWriteReg
);

  logic [OPC_W-1:0]  w_opcode;
  logic [WORD_W-1:0] w_immediate;
  logic              w_active;
  logic              w_hazard;
  logic              w_taken;
  logic [PC_W-1:0]   w_target;
  logic [PC_W-1:0]   w_offset;
  logic              w_unused;
  exe_word_t         w_exe_next;
  exe_word_t         r_exe;

  assign w_opcode = instruction[31:26];
  assign regAAddr = instruction[20:16];
  assign regBAddr = instruction[15:11];
  assign w_active = validInstruction & ~stallIn & cpuReset;
  assign w_offset = {{4{instruction[25]}}, instruction[25:0]};
  assign w_unused = ^jumpRegisterValue[1:0];

  immediateGenerator u_imm (
    .i_opcode      (w_opcode),
    .i_fields      (instruction[25:0]),
    .o_immediate_c (w_immediate)
  );

  // Conservative load-use check: both read fields compared whatever the format.
  assign w_hazard = w_active & r_exe.valid & r_exe.is_load & (r_exe.write_reg != '0) &
                    ((r_exe.write_reg == regAAddr) | (r_exe.write_reg == regBAddr));

  // Branch/jump resolution; target is driven even when not taken.
  always_comb begin
    w_taken  = 1'b0;
    w_target = PC_W'(programCounter + w_offset);
    case (w_opcode)
      OPC_J, OPC_JAL: w_taken = 1'b1;
      OPC_BNF:        w_taken = ~flagIn;
      OPC_BF:         w_taken = flagIn;
      OPC_JR, OPC_JALR: begin
        w_taken  = 1'b1;
        w_target = jumpRegisterValue[31:2];
      end
      default: ;
    endcase
  end

  assign doJump     = w_active & w_taken & ~w_hazard;
  assign jumpTarget = w_target;
  assign insertNop  = w_hazard;

  // Next execute word: a bubble unless a valid, hazard-free instruction is presented.
  always_comb begin
    w_exe_next              = '0;
    w_exe_next.instruction  = NOP_INSTRUCTION;
    w_exe_next.pc           = programCounter;
    w_exe_next.link_address = linkAddress;
    w_exe_next.immediate    = w_immediate;
    if (validInstruction && !w_hazard) begin
      w_exe_next.valid       = 1'b1;
      w_exe_next.instruction = instruction;
      w_exe_next.is_load     = is_load(w_opcode);
      w_exe_next.write_reg   = (w_opcode == OPC_JAL || w_opcode == OPC_JALR) ?
                               LINK_REG : instruction[25:21];
    end
  end

  always_ff @(posedge cpuClock) begin
    if (!cpuReset) begin
      r_exe             <= '0;
      r_exe.instruction <= NOP_INSTRUCTION;
    end else if (!stallIn) begin
      r_exe <= w_exe_next;
    end
  end

  assign exeValid       = r_exe.valid;
  assign exeInstruction = r_exe.instruction;
  assign exePc          = r_exe.pc;
  assign exeLinkAddress = r_exe.link_address;
  assign exeImmediate   = r_exe.immediate;
  assign exeIsLoad      = r_exe.is_load;
  assign exeWriteReg    = r_exe.write_reg;

endmodule
